uart_key_decode: RTL and testbench

- Converts UART receive bytes into debounced, held direction levels and a reset pulse for the pacman game core.
- Sits between uart_rx (byte source) and pacman_game (consumer), in the 100 MHz clk domain.
- Understands single-letter keys (WASD/R) and ANSI arrow-key escape sequences (ESC '[' A..D).
- Holds a direction for a configurable time, bridging terminal auto-repeat gaps.

---
 rtl/pacman_pkg.sv | 86 ++++++++
 rtl/key_hold_timer.sv | 44 ++++
 rtl/uart_key_decode.sv | 189 ++++++++++++++++++
 tb/tb_uart_key_decode.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pacman_pkg
// Description : Shared types and constants for the pacman keyboard path.
//               ASCII codes, the direction enum, the escape-parser state
//               enum and two small byte-decode helper functions.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pacman_pkg;

  // Escape-sequence framing bytes
  localparam logic [7:0] ASC_ESC   = 8'h1B;
  localparam logic [7:0] ASC_CSI   = 8'h5B;

  // Single-letter keys, lower and upper case
  localparam logic [7:0] ASC_W_LO  = 8'h77;
  localparam logic [7:0] ASC_W_UP  = 8'h57;
  localparam logic [7:0] ASC_S_LO  = 8'h73;
  localparam logic [7:0] ASC_S_UP  = 8'h53;
  localparam logic [7:0] ASC_A_LO  = 8'h61;
  localparam logic [7:0] ASC_A_UP  = 8'h41;
  localparam logic [7:0] ASC_D_LO  = 8'h64;
  localparam logic [7:0] ASC_D_UP  = 8'h44;
  localparam logic [7:0] ASC_R_LO  = 8'h72;
  localparam logic [7:0] ASC_R_UP  = 8'h52;

  // Final byte of an ANSI arrow sequence (ESC [ x)
  localparam logic [7:0] ARROW_UP    = 8'h41;
  localparam logic [7:0] ARROW_DOWN  = 8'h42;
  localparam logic [7:0] ARROW_RIGHT = 8'h43;
  localparam logic [7:0] ARROW_LEFT  = 8'h44;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GOT_ESC = 2'd1,
    GOT_CSI = 2'd2
  } esc_state_t;

  // Result of decoding one byte: a direction and/or a game-reset request
  typedef struct packed {
    dir_t dir;
    logic rst;
  } key_cmd_t;

  // Decode a byte seen outside an escape sequence. ESC itself is handled
  // by the parser and yields no command here.
  function automatic key_cmd_t decode_idle(input logic [7:0] b);
    key_cmd_t cmd;
    cmd.dir = DIR_NONE;
    cmd.rst = 1'b0;
    case (b)
      ASC_W_LO, ASC_W_UP: cmd.dir = DIR_UP;
      ASC_S_LO, ASC_S_UP: cmd.dir = DIR_DOWN;
      ASC_A_LO, ASC_A_UP: cmd.dir = DIR_LEFT;
      ASC_D_LO, ASC_D_UP: cmd.dir = DIR_RIGHT;
      ASC_R_LO, ASC_R_UP: cmd.rst = 1'b1;
      default:            cmd.dir = DIR_NONE;
    endcase
    return cmd;
  endfunction

  // Decode the final byte of ESC [ x. Note 'D' means left here but right
  // as a plain letter.
  function automatic dir_t decode_arrow(input logic [7:0] b);
    dir_t d;
    case (b)
      ARROW_UP:    d = DIR_UP;
      ARROW_DOWN:  d = DIR_DOWN;
      ARROW_RIGHT: d = DIR_RIGHT;
      ARROW_LEFT:  d = DIR_LEFT;
      default:     d = DIR_NONE;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : key_hold_timer
// Description : Loadable saturating down-counter. load sets it to CYCLES-1,
//               clear forces it to 0, otherwise it counts down to 0 and stops.
// Ports       : clk     - clock
//               rstn    - asynchronous active-low reset
//               load    - reload with CYCLES-1
//               clear   - force to zero (wins over load)
//               expired - high while the count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module key_hold_timer #(
  parameter int CYCLES = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic clear,
  output logic expired
);

  localparam int                c_width    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [c_width-1:0] c_load_val = c_width'(CYCLES - 1);
  localparam logic [c_width-1:0] c_one      = c_width'(1);

  logic [c_width-1:0] r_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= c_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - c_one;
    end
  end

  assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_key_decode.sv
`default_nettype none
// ============================================================================
// Module      : uart_key_decode
// Description : Turns UART receive bytes into held direction levels and a
//               one-cycle game-reset pulse. Accepts WASD/R letters and ANSI
//               arrow sequences (ESC [ A..D). Each accepted direction stays
//               asserted for HOLD_CYCLES after its last byte so terminal
//               auto-repeat gaps do not make the level flicker.
// Ports       : clk       - 100 MHz system clock
//               rstn      - asynchronous active-low reset
//               rx_data   - received byte, qualified by rx_valid
//               rx_valid  - one-cycle strobe per received byte
//               key_up    - level, up held
//               key_down  - level, down held
//               key_left  - level, left held
//               key_right - level, right held
//               key_reset - one-cycle game reset pulse
//               dir_evt   - one-cycle pulse per accepted direction
// Revision    : 1.0 - initial release
// ============================================================================
module uart_key_decode
  import pacman_pkg::*;
#(
  parameter int HOLD_CYCLES = 12_000_000,
  parameter int ESC_CYCLES  = 200_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       key_up,
  output logic       key_down,
  output logic       key_left,
  output logic       key_right,
  output logic       key_reset,
  output logic       dir_evt
);

  esc_state_t r_state;
  esc_state_t w_state_next;
  key_cmd_t   w_cmd;
  logic       w_esc_load;
  logic       w_esc_expired;
  logic       w_hold_expired;
  logic       w_dir_valid;

  // Direction levels, bit order {up, down, left, right}
  logic [3:0] r_levels;
  logic       r_key_reset;
  logic       r_dir_evt;

  // --------------------------------------------------------------------------
  // Escape parser: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Escape parser: next state. A byte arriving on the timeout cycle is
  // still processed, so rx_valid is always tested before expiry.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (rx_valid && (rx_data == ASC_ESC)) begin
          w_state_next = GOT_ESC;
        end
      end
      GOT_ESC: begin
        if (rx_valid) begin
          if (rx_data == ASC_CSI) begin
            w_state_next = GOT_CSI;
          end else if (rx_data == ASC_ESC) begin
            w_state_next = GOT_ESC;
          end else begin
            w_state_next = IDLE;
          end
        end else if (w_esc_expired) begin
          w_state_next = IDLE;
        end
      end
      GOT_CSI: begin
        if (rx_valid || w_esc_expired) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Escape parser: decode outputs. A non-'[' byte after ESC abandons the
  // sequence and is decoded as a plain key in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_cmd.dir  = DIR_NONE;
    w_cmd.rst  = 1'b0;
    w_esc_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          w_cmd      = decode_idle(rx_data);
          w_esc_load = (rx_data == ASC_ESC);
        end
      end
      GOT_ESC: begin
        if (rx_valid) begin
          if ((rx_data == ASC_CSI) || (rx_data == ASC_ESC)) begin
            w_esc_load = 1'b1;
          end else begin
            w_cmd = decode_idle(rx_data);
          end
        end
      end
      GOT_CSI: begin
        if (rx_valid) begin
          w_cmd.dir = decode_arrow(rx_data);
        end
      end
      default: begin
        w_cmd.dir  = DIR_NONE;
        w_cmd.rst  = 1'b0;
        w_esc_load = 1'b0;
      end
    endcase
  end

  assign w_dir_valid = (w_cmd.dir != DIR_NONE);

  // --------------------------------------------------------------------------
  // Timers
  // --------------------------------------------------------------------------
  key_hold_timer #(
    .CYCLES (ESC_CYCLES)
  ) u_esc_timer (
    .clk     (clk),
    .rstn    (rstn),
    .load    (w_esc_load),
    .clear   (1'b0),
    .expired (w_esc_expired)
  );

  key_hold_timer #(
    .CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk     (clk),
    .rstn    (rstn),
    .load    (w_dir_valid),
    .clear   (w_cmd.rst),
    .expired (w_hold_expired)
  );

  // --------------------------------------------------------------------------
  // Registered outputs. The hold counter sits at CYCLES-1 on the first high
  // cycle, so clearing on its zero cycle gives exactly HOLD_CYCLES high
  // cycles. A new direction always takes priority over expiry.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_levels    <= 4'b0000;
      r_key_reset <= 1'b0;
      r_dir_evt   <= 1'b0;
    end else begin
      r_key_reset <= w_cmd.rst;
      r_dir_evt   <= w_dir_valid;
      if (w_dir_valid) begin
        r_levels <= {(w_cmd.dir == DIR_UP),   (w_cmd.dir == DIR_DOWN),
                     (w_cmd.dir == DIR_LEFT), (w_cmd.dir == DIR_RIGHT)};
      end else if (w_cmd.rst || w_hold_expired) begin
        r_levels <= 4'b0000;
      end
    end
  end

  assign key_up    = r_levels[3];
  assign key_down  = r_levels[2];
  assign key_left  = r_levels[1];
  assign key_right = r_levels[0];
  assign key_reset = r_key_reset;
  assign dir_evt   = r_dir_evt;

endmodule
`default_nettype wire

// File: tb/tb_uart_key_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_key_decode
// Description : Self-checking bench for uart_key_decode. Directed scenarios
//               followed by random byte streams; a byte-level reference model
//               predicts events and hold windows, a monitor checks them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_key_decode;

  localparam int HOLD = 100;
  localparam int ESC  = 20;

  // Event kinds: 0 none, 1 up, 2 down, 3 left, 4 right, 5 game reset
  typedef struct {
    int cyc;
    int kind;
  } rec_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       key_up, key_down, key_left, key_right, key_reset, dir_evt;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  rec_t evt_q[$];   // expected pulses, stamped with the cycle they appear
  rec_t lvl_q[$];   // level-changing events, stamped with the byte cycle
  int   cur_kind = 0;
  int   cur_cyc  = 0;

  logic [7:0] pend[$];  // bytes of an escape sequence in progress
  int         pend_t = 0;
  rec_t       e;

  uart_key_decode #(
    .HOLD_CYCLES (HOLD),
    .ESC_CYCLES  (ESC)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_left  (key_left),
    .key_right (key_right),
    .key_reset (key_reset),
    .dir_evt   (dir_evt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  function automatic int letter_kind(input logic [7:0] b);
    case (b)
      "w", "W": return 1;
      "s", "S": return 2;
      "a", "A": return 3;
      "d", "D": return 4;
      "r", "R": return 5;
      default:  return 0;
    endcase
  endfunction

  task automatic push_kind(input int k, input int n);
    if (k != 0) begin
      evt_q.push_back('{cyc: n + 1, kind: k});
      lvl_q.push_back('{cyc: n, kind: k});
    end
  endtask

  // A sequence is still alive if its previous byte came at most ESC cycles ago.
  task automatic model_byte(input logic [7:0] b, input int n);
    int k;
    k = 0;
    if (pend.size() != 0 && (n - pend_t) > ESC) pend.delete();
    if (pend.size() == 1) begin
      if (b == 8'h5B) begin
        pend.push_back(b);
        pend_t = n;
        return;
      end
      if (b == 8'h1B) begin
        pend_t = n;
        return;
      end
      pend.delete();
    end else if (pend.size() == 2) begin
      pend.delete();
      case (b)
        "A":     k = 1;
        "B":     k = 2;
        "C":     k = 4;
        "D":     k = 3;
        default: k = 0;
      endcase
      push_kind(k, n);
      return;
    end
    if (b == 8'h1B) begin
      pend.push_back(b);
      pend_t = n;
      return;
    end
    push_kind(letter_kind(b), n);
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    int         act;
    logic [3:0] exp_lv;
    logic [3:0] act_lv;
    if (mon_en && rstn) begin
      while (lvl_q.size() != 0 && lvl_q[0].cyc < cyc) begin
        cur_kind = (lvl_q[0].kind == 5) ? 0 : lvl_q[0].kind;
        cur_cyc  = lvl_q[0].cyc;
        void'(lvl_q.pop_front());
      end
      act_lv = {key_up, key_down, key_left, key_right};
      exp_lv = 4'b0000;
      if (cur_kind != 0 && (cyc - cur_cyc) <= HOLD) exp_lv = 4'b1000 >> (cur_kind - 1);
      tests++;
      if (act_lv !== exp_lv) begin
        fails++;
        $display("FAIL levels @%0d: got udlr=%b expected %b", cyc, act_lv, exp_lv);
      end

      act = 0;
      if (dir_evt) begin
        case (act_lv)
          4'b1000: act = 1;
          4'b0100: act = 2;
          4'b0010: act = 3;
          4'b0001: act = 4;
          default: act = 8;
        endcase
      end
      if (key_reset) act = dir_evt ? 9 : 5;
      if (act != 0) begin
        tests++;
        if (evt_q.size() == 0) begin
          fails++;
          $display("FAIL event @%0d: got kind %0d, expected none", cyc, act);
        end else begin
          e = evt_q.pop_front();
          if (e.kind != act || e.cyc != cyc) begin
            fails++;
            $display("FAIL event @%0d: got kind %0d, expected kind %0d @%0d",
                     cyc, act, e.kind, e.cyc);
          end
        end
      end else if (evt_q.size() != 0 && evt_q[0].cyc <= cyc) begin
        tests++;
        fails++;
        $display("FAIL event @%0d: got none, expected kind %0d", cyc, evt_q[0].kind);
        void'(evt_q.pop_front());
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    model_byte(b, cyc);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    wait_cycles(gap);
  endtask

  task automatic check_all_zero(input string name);
    tests++;
    if ({key_up, key_down, key_left, key_right, key_reset, dir_evt} !== 6'b0) begin
      fails++;
      $display("FAIL %s: got outputs %b, expected 000000", name,
               {key_up, key_down, key_left, key_right, key_reset, dir_evt});
    end
  endtask

  logic [7:0] letters [8] = '{"w", "W", "s", "S", "a", "A", "d", "D"};

  initial begin
    rstn = 1'b0;
    wait_cycles(3);
    check_all_zero("reset_state");
    rstn   = 1'b1;
    mon_en = 1'b1;
    wait_cycles(5);

    // Single letter, full hold window
    send("w", 120);
    // Direction change mid-hold
    send("d", 39);
    send("a", 120);
    // Arrow sequence, then plain 'A'
    send(8'h1B, 4);
    send(8'h5B, 4);
    send(8'h41, 10);
    send(8'h41, 120);
    // Timed-out sequence, then ESC followed by a letter
    send(8'h1B, 25);
    send(8'h5B, 3);
    send(8'h41, 10);
    send(8'h1B, 2);
    send("w", 120);
    // Auto-repeat bridging
    repeat (5) send("s", 59);
    wait_cycles(110);
    // Reset key while holding, then back-to-back reset keys
    send("w", 10);
    send("R", 0);
    send("r", 5);
    // Escape chained on ESC, and a sequence completed exactly at expiry
    send(8'h1B, 5);
    send(8'h1B, ESC - 1);
    send(8'h5B, ESC - 1);
    send(8'h43, 30);

    // Asynchronous reset in the middle of a sequence
    send("w", 10);
    send(8'h1B, 3);
    send(8'h5B, 2);
    #3;
    rstn = 1'b0;
    #1;
    check_all_zero("async_reset");
    evt_q.delete();
    lvl_q.delete();
    pend.delete();
    cur_kind = 0;
    wait_cycles(2);
    rstn = 1'b1;
    wait_cycles(2);
    send(8'h41, 120);

    // Random byte streams
    for (int i = 0; i < 300; i++) begin
      int         r;
      int         gap;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 30)      b = letters[$urandom_range(0, 7)];
      else if (r < 36) b = (r < 33) ? 8'h72 : 8'h52;
      else if (r < 52) b = 8'h1B;
      else if (r < 64) b = 8'h5B;
      else if (r < 80) b = 8'(8'h41 + $urandom_range(0, 3));
      else             b = 8'($urandom);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 130) : $urandom_range(0, 25);
      send(b, gap);
    end

    wait_cycles(HOLD + 10);
    tests++;
    if (evt_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending events, expected 0", evt_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
